// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Shares the single-port FISC register file between NREQ requesters with
// round-robin arbitration, and runs the exception-entry save sequence
// (pc->elr, cpsr->spsr[mode], evp->pc) ahead of any pending requester.
module regfile_sequencer #(
  parameter int NREQ   = 3,
  parameter int INT_SZ = 64,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req_valid,
  output logic [NREQ-1:0]        o_req_ready,
  input  logic [2*NREQ-1:0]      i_req_op,
  input  logic [6*NREQ-1:0]      i_req_rd,
  input  logic [6*NREQ-1:0]      i_req_wr,
  input  logic [INT_SZ*NREQ-1:0] i_req_data,
  output logic                   o_rsp_valid,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [INT_SZ-1:0]      o_rsp_data,
  output logic                   o_rsp_err,
  input  logic                   i_exc_req,
  input  logic [2:0]             i_exc_mode,
  output logic                   o_exc_ack,
  output logic [5:0]             o_rf_rd_reg,
  output logic [5:0]             o_rf_wr_reg,
  output logic                   o_rf_wr_fromreg,
  output logic                   o_rf_wr_fromimm,
  output logic [INT_SZ-1:0]      o_rf_din,
  input  logic [INT_SZ-1:0]      i_rf_dout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_EXC_PC,
    ST_EXC_PSR,
    ST_EXC_VEC,
    ST_EXC_ACK
  } state_t;

  localparam logic [1:0] OPC_READ  = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_MOVE  = 2'b10;
  localparam logic [1:0] OPC_ILL   = 2'b11;

  localparam logic [5:0] REG_LAST = 6'd45;
  localparam logic [5:0] REG_PC   = 6'd32;
  localparam logic [5:0] REG_ELR  = 6'd34;
  localparam logic [5:0] REG_CPSR = 6'd35;
  localparam logic [5:0] REG_SPSR = 6'd36;
  localparam logic [5:0] REG_EVP  = 6'd43;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDW-1:0]      r_rr_ptr;
  logic [1:0]          r_op;
  logic [5:0]          r_rd;
  logic [5:0]          r_wr;
  logic [INT_SZ-1:0]   r_data;
  logic [IDW-1:0]      r_id;
  logic                r_err;
  logic [2:0]          r_exc_mode;
  logic                r_rsp_valid;
  logic [IDW-1:0]      r_rsp_id;
  logic [INT_SZ-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic                w_grant_found;
  logic [IDW-1:0]      w_grant_idx;
  logic                w_take;
  logic [1:0]          w_sel_op;
  logic [5:0]          w_sel_rd;
  logic [5:0]          w_sel_wr;
  logic                w_sel_err;

  // Round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_grant_found && i_req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  // Grant only from IDLE and only when no exception is waiting; payload is picked here
  always_comb begin
    w_take    = (r_state == ST_IDLE) && !i_rst && !i_exc_req && w_grant_found;
    w_sel_op  = i_req_op[2*w_grant_idx +: 2];
    w_sel_rd  = i_req_rd[6*w_grant_idx +: 6];
    w_sel_wr  = i_req_wr[6*w_grant_idx +: 6];
    w_sel_err = (w_sel_op == OPC_ILL) ||
                ((w_sel_op == OPC_READ || w_sel_op == OPC_MOVE) && (w_sel_rd > REG_LAST)) ||
                ((w_sel_op == OPC_WRITE || w_sel_op == OPC_MOVE) && (w_sel_wr > REG_LAST));
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: exceptions win over requesters; mode 6/7 has no spsr slot
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_exc_req) begin
          w_next_state = ST_EXC_PC;
        end else if (w_grant_found) begin
          w_next_state = ST_OP;
        end
      end
      ST_OP:      w_next_state = ST_IDLE;
      ST_EXC_PC:  w_next_state = (r_exc_mode < 3'd6) ? ST_EXC_PSR : ST_EXC_VEC;
      ST_EXC_PSR: w_next_state = ST_EXC_VEC;
      ST_EXC_VEC: w_next_state = ST_EXC_ACK;
      ST_EXC_ACK: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Latch the granted request, the exception mode and the registered response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_op        <= OPC_READ;
      r_rd        <= '0;
      r_wr        <= '0;
      r_data      <= '0;
      r_id        <= '0;
      r_err       <= 1'b0;
      r_exc_mode  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_op     <= w_sel_op;
        r_rd     <= w_sel_rd;
        r_wr     <= w_sel_wr;
        r_data   <= i_req_data[INT_SZ*w_grant_idx +: INT_SZ];
        r_id     <= w_grant_idx;
        r_err    <= w_sel_err;
        r_rr_ptr <= (w_grant_idx == IDW'(NREQ-1)) ? '0 : w_grant_idx + IDW'(1);
      end
      if (r_state == ST_IDLE && i_exc_req) begin
        r_exc_mode <= i_exc_mode;
      end
      r_rsp_valid <= (r_state == ST_OP);
      if (r_state == ST_OP) begin
        r_rsp_id   <= r_id;
        r_rsp_err  <= r_err;
        r_rsp_data <= (!r_err && r_op == OPC_READ) ? i_rf_dout : '0;
      end else begin
        r_rsp_id   <= '0;
        r_rsp_err  <= 1'b0;
        r_rsp_data <= '0;
      end
    end
  end

  // Output decode: register file lanes come straight from the current state
  always_comb begin
    o_req_ready     = '0;
    o_rf_rd_reg     = '0;
    o_rf_wr_reg     = '0;
    o_rf_wr_fromreg = 1'b0;
    o_rf_wr_fromimm = 1'b0;
    o_rf_din        = '0;
    o_exc_ack       = 1'b0;
    if (w_take) begin
      o_req_ready[w_grant_idx] = 1'b1;
    end
    case (r_state)
      ST_OP: begin
        if (!r_err) begin
          case (r_op)
            OPC_READ: begin
              o_rf_rd_reg = r_rd;
            end
            OPC_WRITE: begin
              o_rf_wr_reg     = r_wr;
              o_rf_din        = r_data;
              o_rf_wr_fromimm = 1'b1;
            end
            OPC_MOVE: begin
              o_rf_rd_reg     = r_rd;
              o_rf_wr_reg     = r_wr;
              o_rf_wr_fromreg = 1'b1;
            end
            default: begin
              o_rf_rd_reg = '0;
            end
          endcase
        end
      end
      ST_EXC_PC: begin
        o_rf_rd_reg     = REG_PC;
        o_rf_wr_reg     = REG_ELR;
        o_rf_wr_fromreg = 1'b1;
      end
      ST_EXC_PSR: begin
        o_rf_rd_reg     = REG_CPSR;
        o_rf_wr_reg     = REG_SPSR + {3'b000, r_exc_mode};
        o_rf_wr_fromreg = 1'b1;
      end
      ST_EXC_VEC: begin
        o_rf_rd_reg     = REG_EVP;
        o_rf_wr_reg     = REG_PC;
        o_rf_wr_fromreg = 1'b1;
      end
      ST_EXC_ACK: begin
        o_exc_ack = 1'b1;
      end
      default: begin
        o_exc_ack = 1'b0;
      end
    endcase
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer
// Drives directed and random traffic into regfile_sequencer, hosts a simple
// register-file model on its rf_* lanes, and scores responses against a
// reference model of the register file contents and arbitration order.
module tb_regfile_sequencer;

  localparam int NREQ   = 3;
  localparam int INT_SZ = 64;
  localparam int IDW    = 2;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic [NREQ-1:0]        i_req_valid = '0;
  logic [NREQ-1:0]        o_req_ready;
  logic [2*NREQ-1:0]      i_req_op = '0;
  logic [6*NREQ-1:0]      i_req_rd = '0;
  logic [6*NREQ-1:0]      i_req_wr = '0;
  logic [INT_SZ*NREQ-1:0] i_req_data = '0;
  logic                   o_rsp_valid;
  logic [IDW-1:0]         o_rsp_id;
  logic [INT_SZ-1:0]      o_rsp_data;
  logic                   o_rsp_err;
  logic                   i_exc_req = 1'b0;
  logic [2:0]             i_exc_mode = '0;
  logic                   o_exc_ack;
  logic [5:0]             o_rf_rd_reg;
  logic [5:0]             o_rf_wr_reg;
  logic                   o_rf_wr_fromreg;
  logic                   o_rf_wr_fromimm;
  logic [INT_SZ-1:0]      o_rf_din;
  logic [INT_SZ-1:0]      rfDout;

  regfile_sequencer #(.NREQ(NREQ), .INT_SZ(INT_SZ), .IDW(IDW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_rd(i_req_rd), .i_req_wr(i_req_wr), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .i_exc_req(i_exc_req), .i_exc_mode(i_exc_mode), .o_exc_ack(o_exc_ack),
    .o_rf_rd_reg(o_rf_rd_reg), .o_rf_wr_reg(o_rf_wr_reg),
    .o_rf_wr_fromreg(o_rf_wr_fromreg), .o_rf_wr_fromimm(o_rf_wr_fromimm),
    .o_rf_din(o_rf_din), .i_rf_dout(rfDout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          ack;
    bit          useRd;
    bit          useWr;
    bit          useDin;
    bit          imm;
    bit          mov;
    logic [5:0]  rd;
    logic [5:0]  wr;
    logic [63:0] din;
  } cyc_t;

  typedef struct {
    int          id;
    logic [63:0] data;
    bit          err;
    int          due;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          ackCount = 0;
  logic [63:0] tbRf [64];
  logic [63:0] refRegs [64];
  bit          preloadDone = 1'b0;
  bit          modelInit = 1'b0;
  int          refPtr = 0;
  cyc_t        expSeq [$];
  rsp_t        rspQ [$];
  int          grantLog [$];

  function automatic logic [63:0] initVal(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0001_0001_0001);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycleCnt);
    end
  endtask

  // Behavioural register file hanging off the rf_* lanes (combinational read)
  always @(posedge i_clk) begin
    if (!preloadDone) begin
      for (int i = 0; i < 64; i++) tbRf[i] <= initVal(i);
      preloadDone <= 1'b1;
    end else begin
      if (o_rf_wr_fromimm === 1'b1) tbRf[o_rf_wr_reg] <= o_rf_din;
      if (o_rf_wr_fromreg === 1'b1) tbRf[o_rf_wr_reg] <= tbRf[o_rf_rd_reg];
    end
  end

  assign rfDout = (o_rf_rd_reg <= 6'd45) ? tbRf[o_rf_rd_reg] : 64'd0;

  always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

  always @(negedge i_clk) begin
    if (o_exc_ack === 1'b1) ackCount = ackCount + 1;
  end

  // Reference model: one step per cycle, tracking busy cycles, arbitration and register contents
  always @(negedge i_clk) begin : refModel
    cyc_t        e;
    rsp_t        r;
    int          g;
    int          m;
    logic [1:0]  op;
    logic [5:0]  rd;
    logic [5:0]  wr;
    logic [63:0] d;
    bit          err;
    if (!modelInit) begin
      for (int i = 0; i < 64; i++) refRegs[i] = initVal(i);
      modelInit = 1'b1;
    end
    if (i_rst) begin
      expSeq.delete();
      rspQ.delete();
      refPtr = 0;
    end else if (expSeq.size() > 0) begin
      e = expSeq.pop_front();
      checkOutput("busy_ready", 64'(o_req_ready), 64'd0);
      checkOutput("fromimm", 64'(o_rf_wr_fromimm), 64'(e.imm));
      checkOutput("fromreg", 64'(o_rf_wr_fromreg), 64'(e.mov));
      checkOutput("exc_ack", 64'(o_exc_ack), 64'(e.ack));
      if (e.useRd)  checkOutput("rf_rd_reg", 64'(o_rf_rd_reg), 64'(e.rd));
      if (e.useWr)  checkOutput("rf_wr_reg", 64'(o_rf_wr_reg), 64'(e.wr));
      if (e.useDin) checkOutput("rf_din", o_rf_din, e.din);
    end else begin
      checkOutput("idle_rf_lanes", 64'({o_rf_rd_reg, o_rf_wr_reg, o_rf_wr_fromreg, o_rf_wr_fromimm, o_exc_ack}), 64'd0);
      checkOutput("idle_rf_din", o_rf_din, 64'd0);
      if (i_exc_req) begin
        checkOutput("exc_no_grant", 64'(o_req_ready), 64'd0);
        m = int'(i_exc_mode);
        refRegs[34] = refRegs[32];
        expSeq.push_back('{ack: 0, useRd: 1, useWr: 1, useDin: 0, imm: 0, mov: 1, rd: 6'd32, wr: 6'd34, din: '0});
        if (m < 6) begin
          refRegs[36 + m] = refRegs[35];
          expSeq.push_back('{ack: 0, useRd: 1, useWr: 1, useDin: 0, imm: 0, mov: 1, rd: 6'd35, wr: 6'(36 + m), din: '0});
        end
        refRegs[32] = refRegs[43];
        expSeq.push_back('{ack: 0, useRd: 1, useWr: 1, useDin: 0, imm: 0, mov: 1, rd: 6'd43, wr: 6'd32, din: '0});
        expSeq.push_back('{ack: 1, useRd: 0, useWr: 0, useDin: 0, imm: 0, mov: 0, rd: '0, wr: '0, din: '0});
      end else if (|i_req_valid) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && i_req_valid[(refPtr + k) % NREQ]) g = (refPtr + k) % NREQ;
        end
        checkOutput("grant", 64'(o_req_ready), 64'd1 << g);
        grantLog.push_back(g);
        refPtr = (g + 1) % NREQ;
        op  = i_req_op[2*g +: 2];
        rd  = i_req_rd[6*g +: 6];
        wr  = i_req_wr[6*g +: 6];
        d   = i_req_data[64*g +: 64];
        err = (op == 2'b11) || (op != 2'b01 && rd > 6'd45) || (op != 2'b00 && wr > 6'd45);
        r.id = g; r.err = err; r.data = 64'd0; r.due = cycleCnt + 2;
        e = '{ack: 0, useRd: 0, useWr: 0, useDin: 0, imm: 0, mov: 0, rd: rd, wr: wr, din: d};
        if (!err) begin
          case (op)
            2'b00: begin r.data = refRegs[rd]; e.useRd = 1; end
            2'b01: begin refRegs[wr] = d; e.useWr = 1; e.useDin = 1; e.imm = 1; end
            default: begin refRegs[wr] = refRegs[rd]; e.useRd = 1; e.useWr = 1; e.mov = 1; end
          endcase
        end
        rspQ.push_back(r);
        expSeq.push_back(e);
      end else begin
        checkOutput("idle_ready", 64'(o_req_ready), 64'd0);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge i_clk) begin : rspMonitor
    rsp_t r;
    while (rspQ.size() > 0 && rspQ[0].due < cycleCnt) begin
      r = rspQ.pop_front();
      checkOutput("rsp_missing", 64'd0, 64'd1);
    end
    if (o_rsp_valid === 1'b1) begin
      if (rspQ.size() == 0) begin
        checkOutput("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        r = rspQ.pop_front();
        checkOutput("rsp_cycle", 64'(cycleCnt), 64'(r.due));
        checkOutput("rsp_id", 64'(o_rsp_id), 64'(r.id));
        checkOutput("rsp_data", o_rsp_data, r.data);
        checkOutput("rsp_err", 64'(o_rsp_err), 64'(r.err));
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [5:0] rd,
                               input logic [5:0] wr, input logic [63:0] data);
    bit granted = 1'b0;
    @(posedge i_clk); #1;
    i_req_valid[idx]          = 1'b1;
    i_req_op[2*idx +: 2]      = op;
    i_req_rd[6*idx +: 6]      = rd;
    i_req_wr[6*idx +: 6]      = wr;
    i_req_data[64*idx +: 64]  = data;
    for (int c = 0; c < 40 && !granted; c++) begin
      @(negedge i_clk);
      if (o_req_ready[idx] === 1'b1) granted = 1'b1;
    end
    if (!granted) checkOutput("grant_timeout", 64'd0, 64'd1);
    @(posedge i_clk); #1;
    i_req_valid[idx] = 1'b0;
  endtask

  task automatic waitAck(input int base);
    bit seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge i_clk); #1;
      if (ackCount != base) seen = 1'b1;
    end
    if (!seen) checkOutput("ack_timeout", 64'd0, 64'd1);
    @(posedge i_clk); #1;
    i_exc_req = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge i_clk); #1;
      if (expSeq.size() == 0 && rspQ.size() == 0) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : mainSeq
    int          base;
    logic [63:0] snap [6];
    logic [1:0]  opPick;
    int          r;

    // Reset values
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_ready", 64'(o_req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    checkOutput("rst_rsp_id", 64'(o_rsp_id), 64'd0);
    checkOutput("rst_rsp_data", o_rsp_data, 64'd0);
    checkOutput("rst_rsp_err", 64'(o_rsp_err), 64'd0);
    checkOutput("rst_exc_ack", 64'(o_exc_ack), 64'd0);
    checkOutput("rst_rf_lanes", 64'({o_rf_rd_reg, o_rf_wr_reg, o_rf_wr_fromreg, o_rf_wr_fromimm}), 64'd0);
    checkOutput("rst_rf_din", o_rf_din, 64'd0);

    // All requesters valid continuously from reset
    @(posedge i_clk); #1;
    i_rst       = 1'b0;
    i_req_op    = '0;
    i_req_rd    = {6'd2, 6'd1, 6'd0};
    i_req_valid = 3'b111;
    repeat (12) @(posedge i_clk);
    #1 i_req_valid = '0;
    drain();
    checkOutput("rr_count", 64'(grantLog.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < grantLog.size(); i++) begin
      checkOutput("rr_order", 64'(grantLog[i]), 64'(i % 3));
    end

    // Write then read back through a different requester
    applyStimulus(0, 2'b01, 6'd0, 6'd5, 64'hDEAD);
    applyStimulus(1, 2'b00, 6'd5, 6'd0, 64'd0);
    drain();
    checkOutput("r5_dead", tbRf[5], 64'hDEAD);

    // Exception entry with a requester waiting
    applyStimulus(0, 2'b01, 6'd0, 6'd32, 64'h1000);
    applyStimulus(1, 2'b01, 6'd0, 6'd35, 64'h0A5);
    applyStimulus(2, 2'b01, 6'd0, 6'd43, 64'h8000);
    drain();
    @(posedge i_clk); #1;
    base = ackCount;
    i_exc_req = 1'b1;
    i_exc_mode = 3'd2;
    i_req_valid[0] = 1'b1;
    i_req_op[1:0] = 2'b00;
    i_req_rd[5:0] = 6'd34;
    waitAck(base);
    applyStimulus(0, 2'b00, 6'd34, 6'd0, 64'd0);
    drain();
    checkOutput("elr", tbRf[34], 64'h1000);
    checkOutput("spsr2", tbRf[38], 64'h0A5);
    checkOutput("pc_vec", tbRf[32], 64'h8000);

    // Move into esr, read it back, then an out-of-range read
    applyStimulus(2, 2'b10, 6'd3, 6'd33, 64'd0);
    applyStimulus(0, 2'b00, 6'd33, 6'd0, 64'd0);
    applyStimulus(1, 2'b00, 6'd50, 6'd0, 64'd0);
    drain();
    checkOutput("esr_eq_r3", tbRf[33], tbRf[3]);

    // Mode 7: no spsr slot touched
    for (int i = 0; i < 6; i++) snap[i] = tbRf[36 + i];
    @(posedge i_clk); #1;
    base = ackCount;
    i_exc_req = 1'b1;
    i_exc_mode = 3'd7;
    waitAck(base);
    drain();
    for (int i = 0; i < 6; i++) checkOutput("spsr_keep", tbRf[36 + i], snap[i]);

    // Random traffic
    base = ackCount;
    for (int c = 0; c < 800; c++) begin
      @(posedge i_clk); #1;
      if (i_exc_req && ackCount != base) begin
        i_exc_req = 1'b0;
      end else if (!i_exc_req && $urandom_range(0, 39) == 0) begin
        base = ackCount;
        i_exc_req = 1'b1;
        i_exc_mode = 3'($urandom_range(0, 7));
      end
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 15);
        opPick = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
        i_req_valid[i]         = ($urandom_range(0, 99) < 50);
        i_req_op[2*i +: 2]     = opPick;
        i_req_rd[6*i +: 6]     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(46, 63)) : 6'($urandom_range(0, 45));
        i_req_wr[6*i +: 6]     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(46, 63)) : 6'($urandom_range(0, 45));
        i_req_data[64*i +: 64] = {$urandom, $urandom};
      end
    end
    @(posedge i_clk); #1;
    i_req_valid = '0;
    if (i_exc_req) waitAck(base);
    drain();
    for (int i = 0; i < 64; i++) checkOutput("regfile_final", tbRf[i], refRegs[i]);

    // Reset during the OP cycle of a write
    @(posedge i_clk); #1;
    i_req_valid = 3'b001;
    i_req_op[1:0] = 2'b01;
    i_req_wr[5:0] = 6'd7;
    i_req_data[63:0] = 64'h55;
    @(negedge i_clk);
    checkOutput("rst_test_grant", 64'(o_req_ready), 64'd1);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("rst_op_strobe", 64'(o_rf_wr_fromimm), 64'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("r7_committed", tbRf[7], 64'h55);
    checkOutput("post_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    checkOutput("post_rst_rsp", {o_rsp_data[61:0], o_rsp_id}, 64'd0);
    checkOutput("post_rst_err_ack", 64'({o_rsp_err, o_exc_ack}), 64'd0);
    checkOutput("post_rst_lanes", 64'({o_rf_rd_reg, o_rf_wr_reg, o_rf_wr_fromreg, o_rf_wr_fromimm}), 64'd0);
    checkOutput("post_rst_din", o_rf_din, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checkOutput("no_rsp_after_rst", 64'(o_rsp_valid), 64'd0);
    end

    // Pointer back at 0 after reset: req0 wins over req1
    @(posedge i_clk); #1;
    i_req_op[3:0] = 4'b0000;
    i_req_rd[11:0] = {6'd7, 6'd7};
    i_req_valid = 3'b011;
    @(negedge i_clk);
    checkOutput("rr_after_rst", 64'(o_req_ready), 64'd1);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
